sr_flag_arbiter: RTL and testbench

//   Shares one bank of N_FLAGS set/reset flags between N_REQ requesters.

---
 rtl/sr_flag_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter
// Front-end controller for a shared bank of SR flags. Several requesters post
// set/reset commands. A round-robin arbiter picks one of them, and a two-state
// sequencer (ARB -> COMMIT) latches the winner's command. On the following edge
// it commits the command to the flag bank using SR rules, where reset dominates.
// Each committed command produces a one-cycle ack to its requester. A command
// whose index has no flag behind it still acks, and it also raises err.

module sr_flag_arbiter #(
  parameter int N_REQ     = 4,
  parameter int N_FLAGS   = 8,
  parameter int IDX_W     = $clog2(N_FLAGS),
  parameter int IDX_W_REQ = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       s_in,
  input  logic [N_REQ-1:0]       r_in,
  input  logic [N_REQ*IDX_W-1:0] idx_in,
  output logic [N_REQ-1:0]       ack,
  output logic [N_FLAGS-1:0]     q,
  output logic                   busy,
  output logic [IDX_W_REQ-1:0]   grant_id,
  output logic                   err
);

  typedef enum logic {
    ARB    = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  // Round-robin pointer: the first requester considered in the next search.
  logic [IDX_W_REQ-1:0]   ptr;

  // Arbitration results.
  logic [N_REQ-1:0]       elig;
  logic                   win_vld;
  logic [IDX_W_REQ-1:0]   win_id;

  // Sequencer strobes.
  logic                   latch_en;
  logic                   commit_en;

  // The command latched at the ARB edge and held through COMMIT.
  logic                   cmd_s_p1;
  logic                   cmd_r_p1;
  logic [IDX_W-1:0]       cmd_idx_p1;
  logic [IDX_W_REQ-1:0]   cmd_w_p1;

  // Next value of the flag bank if the latched command is committed.
  logic [N_FLAGS-1:0]     q_nxt;
  logic                   idx_hit;

  // SR flip-flop rule: reset dominates, set forces 1, neither bit set holds.
  function automatic logic sr_apply(input logic cur, input logic s, input logic r);
    if (r)      sr_apply = 1'b0;
    else if (s) sr_apply = 1'b1;
    else        sr_apply = cur;
  endfunction

  // Ack vector with only the committing requester's bit set.
  function automatic logic [N_REQ-1:0] req_onehot(input logic [IDX_W_REQ-1:0] w);
    req_onehot    = '0;
    req_onehot[w] = 1'b1;
  endfunction

  // The pointer moves to the requester just after the one that was served.
  function automatic logic [IDX_W_REQ-1:0] ptr_after(input logic [IDX_W_REQ-1:0] w);
    ptr_after = IDX_W_REQ'((int'(w) + 1) % N_REQ);
  endfunction

  // A requester whose ack is high this cycle is excluded, so it cannot be granted twice for one command.
  assign elig = req & ~ack;

  // Winner search: the first eligible requester at or after ptr, ascending and wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_vld && elig[(int'(ptr) + k) % N_REQ]) begin
        win_vld = 1'b1;
        win_id  = IDX_W_REQ'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARB;
    else        state <= state_nxt;
  end

  // Sequencer next state: grant when someone is eligible, then always return to ARB after one commit cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (win_vld) state_nxt = COMMIT;
      COMMIT:  state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // Sequencer outputs: latch strobe in ARB, commit strobe in COMMIT; busy marks a pending command.
  always_comb begin
    latch_en  = 1'b0;
    commit_en = 1'b0;
    busy      = 1'b0;
    case (state)
      ARB:    latch_en = win_vld;
      COMMIT: begin
        commit_en = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // ---- stage p1: winner's command captured at the ARB edge ----
  // Data capture only. A reset during COMMIT drops the command through the state register.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      cmd_s_p1   <= s_in[win_id];
      cmd_r_p1   <= r_in[win_id];
      cmd_idx_p1 <= idx_in[win_id*IDX_W +: IDX_W];
      cmd_w_p1   <= win_id;
    end
  end

  // Flag-bank update for the latched command. An index with no matching flag leaves every bit alone.
  always_comb begin
    q_nxt   = q;
    idx_hit = 1'b0;
    for (int f = 0; f < N_FLAGS; f++) begin
      if (cmd_idx_p1 == IDX_W'(f)) begin
        idx_hit  = 1'b1;
        q_nxt[f] = sr_apply(q[f], cmd_s_p1, cmd_r_p1);
      end
    end
  end

  // ---- stage p2: commit results visible (q, ack, err) ----
  // The flag bank changes only on a commit edge.
  always_ff @(posedge clk) begin
    if (!rst_n)         q <= '0;
    else if (commit_en) q <= q_nxt;
  end

  // Grant bookkeeping and the one-cycle ack/err pulses that follow each commit edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      grant_id <= '0;
      ack      <= '0;
      err      <= 1'b0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      if (latch_en) grant_id <= win_id;
      if (commit_en) begin
        ack <= req_onehot(cmd_w_p1);
        err <= !idx_hit;
        ptr <= ptr_after(cmd_w_p1);
      end
    end
  end

  // Structural invariants of the pulse outputs.
  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
  a_err_ack:    assert property (@(posedge clk) disable iff (!rst_n) err |-> (|ack));

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter
// Directed bench for sr_flag_arbiter. One instance uses the default 8-flag bank.
// It is tracked every cycle against a transaction-level model. A second
// instance with a 6-flag bank exercises out-of-range indices.

module tb_sr_flag_arbiter;

  localparam int NR = 4;
  localparam int NF = 8;
  localparam int IW = 3;
  localparam int RW = 2;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req, s_in, r_in;
  logic [NR*IW-1:0] idx_in;
  logic [NR-1:0] ack;
  logic [NF-1:0] q;
  logic          busy;
  logic [RW-1:0] grant_id;
  logic          err;

  logic [NR-1:0] req6, s6, r6;
  logic [NR*IW-1:0] idx6;
  logic [NR-1:0] ack6;
  logic [5:0]    q6;
  logic          busy6;
  logic [RW-1:0] gid6;
  logic          err6;

  int checks;
  int failures;

  sr_flag_arbiter #(.N_REQ(NR), .N_FLAGS(NF)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .s_in(s_in), .r_in(r_in), .idx_in(idx_in),
    .ack(ack), .q(q), .busy(busy), .grant_id(grant_id), .err(err)
  );

  sr_flag_arbiter #(.N_REQ(NR), .N_FLAGS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .req(req6), .s_in(s6), .r_in(r6), .idx_in(idx6),
    .ack(ack6), .q(q6), .busy(busy6), .grant_id(gid6), .err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model of the 8-flag instance
  bit started;
  bit pend;
  int pw, pidx;
  bit ps, pr;
  bit mq[NF];
  int rr;
  int m_ack;
  bit m_err;
  int m_gid;
  int prev_ack;

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      pend = 0; rr = 0; m_ack = -1; m_err = 0; m_gid = 0;
      for (int f = 0; f < NF; f++) mq[f] = 0;
    end else if (pend) begin
      if (pidx < NF) begin
        if (pr)      mq[pidx] = 0;
        else if (ps) mq[pidx] = 1;
      end
      m_ack = pw;
      m_err = (pidx >= NF);
      rr    = (pw + 1) % NR;
      pend  = 0;
    end else begin
      prev_ack = m_ack;
      m_ack = -1;
      m_err = 0;
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (rr + k) % NR;
        if (!pend && req[j] && j != prev_ack) begin
          pend = 1; pw = j; ps = s_in[j]; pr = r_in[j];
          pidx = int'(idx_in[j*IW +: IW]);
          m_gid = j;
        end
      end
    end
  end

  logic [NF-1:0] e_q;
  logic [NR-1:0] e_ack;

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      for (int f = 0; f < NF; f++) e_q[f] = mq[f];
      e_ack = (m_ack >= 0) ? (NR'(1) << m_ack) : '0;
      checks++;
      if (q !== e_q) begin failures++; $display("FAIL cyc_q t=%0t got=%h exp=%h", $time, q, e_q); end
      checks++;
      if (ack !== e_ack) begin failures++; $display("FAIL cyc_ack t=%0t got=%b exp=%b", $time, ack, e_ack); end
      checks++;
      if (busy !== pend) begin failures++; $display("FAIL cyc_busy t=%0t got=%b exp=%b", $time, busy, pend); end
      checks++;
      if (grant_id !== RW'(m_gid)) begin failures++; $display("FAIL cyc_gid t=%0t got=%0d exp=%0d", $time, grant_id, m_gid); end
      checks++;
      if (err !== m_err) begin failures++; $display("FAIL cyc_err t=%0t got=%b exp=%b", $time, err, m_err); end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Post one command on requester i, wait (bounded) for its grant, then its ack; drop req in the ack cycle.
  task automatic do_cmd(input int i, input bit s, input bit r, input int ix);
    int n;
    req[i] = 1'b1; s_in[i] = s; r_in[i] = r;
    idx_in[i*IW +: IW] = IW'(ix);
    n = 0;
    do begin step(); n++; end while (!busy && n < 8);
    check("cmd_grant", {31'd0, busy}, 32'd1);
    step();
    check("cmd_ack", {31'd0, ack[i]}, 32'd1);
    req[i] = 1'b0;
  endtask

  int g[8];
  int gcnt;
  int acnt;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    req = '0; s_in = '0; r_in = '0; idx_in = '0;
    req6 = '0; s6 = '0; r6 = '0; idx6 = '0;

    // 1: reset with random requests, then release idle
    for (int c = 0; c < 2; c++) begin
      req = 4'($urandom_range(0, 15));
      s_in = 4'($urandom_range(0, 15));
      step();
    end
    check("rst_q", {24'd0, q}, 32'h0);
    check("rst_ack", {28'd0, ack}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_gid", {30'd0, grant_id}, 32'h0);
    check("rst_err", {31'd0, err}, 32'h0);
    rst_n = 1'b1; req = '0; s_in = '0;
    step(); step();
    check("idle_q", {24'd0, q}, 32'h0);
    check("idle_busy", {31'd0, busy}, 32'h0);

    // 2: single set command from requester 2 on flag 5
    req[2] = 1'b1; s_in[2] = 1'b1; r_in[2] = 1'b0; idx_in[2*IW +: IW] = 3'd5;
    step();
    check("single_busy", {31'd0, busy}, 32'd1);
    check("single_gid", {30'd0, grant_id}, 32'd2);
    step();
    check("single_q", {24'd0, q}, 32'h20);
    check("single_ack", {28'd0, ack}, 32'b0100);
    req[2] = 1'b0;
    step();
    check("single_ack_end", {28'd0, ack}, 32'h0);

    // 3: SR rules on flag 3
    do_cmd(0, 1, 0, 3); check("sr_set", {31'd0, q[3]}, 32'd1);
    do_cmd(0, 0, 0, 3); check("sr_hold", {31'd0, q[3]}, 32'd1);
    do_cmd(0, 1, 1, 3); check("sr_both", {31'd0, q[3]}, 32'd0);
    do_cmd(0, 1, 0, 3); check("sr_set2", {31'd0, q[3]}, 32'd1);
    do_cmd(0, 0, 1, 3); check("sr_reset", {31'd0, q[3]}, 32'd0);
    check("sr_keep5", {24'd0, q}, 32'h20);

    // 4: round-robin from ptr=0 with all four requesting
    rst_n = 1'b0; step(); rst_n = 1'b1;
    s_in = 4'b1111; r_in = '0; idx_in = {3'd3, 3'd2, 3'd1, 3'd0};
    req = 4'b1111;
    gcnt = 0; acnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (busy && gcnt < 8) begin g[gcnt] = int'(grant_id); gcnt++; end
      if (ack != 0) acnt++;
    end
    check("rr_grants", gcnt, 5);
    check("rr_acks", acnt, 5);
    check("rr_g0", g[0], 0);
    check("rr_g1", g[1], 1);
    check("rr_g2", g[2], 2);
    check("rr_g3", g[3], 3);
    check("rr_g4", g[4], 0);
    check("rr_q", {24'd0, q}, 32'h0F);
    // requester 1 alone: no regrant during its own ack cycle
    req = 4'b0010;
    step();
    check("solo_busy", {31'd0, busy}, 32'd1);
    check("solo_gid", {30'd0, grant_id}, 32'd1);
    step();
    check("solo_ack", {28'd0, ack}, 32'b0010);
    check("solo_idle", {31'd0, busy}, 32'd0);
    step();
    check("solo_masked", {31'd0, busy}, 32'd0);
    step();
    check("solo_regrant", {31'd0, busy}, 32'd1);
    check("solo_regid", {30'd0, grant_id}, 32'd1);
    req = '0;
    step(); step();

    // 5: reset while a set of flag 0 sits in COMMIT
    req = 4'b0001; s_in = 4'b0001; r_in = '0; idx_in = '0;
    step();
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    step();
    check("mid_q0", {31'd0, q[0]}, 32'd0);
    check("mid_ack", {28'd0, ack}, 32'h0);
    check("mid_busy0", {31'd0, busy}, 32'd0);
    rst_n = 1'b1; req = '0;
    step();
    check("mid_noack", {28'd0, ack}, 32'h0);
    check("mid_q", {24'd0, q}, 32'h0);
    req = 4'b1001; s_in = 4'b1001; idx_in = {3'd3, 3'd0, 3'd0, 3'd0};
    step();
    check("mid_ptr0", {30'd0, grant_id}, 32'd0);
    req = '0;
    step(); step();

    // 6: 6-flag bank, out-of-range indices
    req6 = 4'b0001; s6 = 4'b0001; idx6[0 +: IW] = 3'd2;
    step(); step();
    check("oor_pre_q", {26'd0, q6}, 32'h04);
    check("oor_pre_ack", {28'd0, ack6}, 32'b0001);
    check("oor_pre_err", {31'd0, err6}, 32'd0);
    req6 = '0;
    step();
    req6 = 4'b0001; idx6[0 +: IW] = 3'd7;
    step(); step();
    check("oor7_q", {26'd0, q6}, 32'h04);
    check("oor7_ack", {28'd0, ack6}, 32'b0001);
    check("oor7_err", {31'd0, err6}, 32'd1);
    req6 = '0;
    step();
    check("oor7_err_end", {31'd0, err6}, 32'd0);
    check("oor7_ack_end", {28'd0, ack6}, 32'h0);
    req6 = 4'b0010; s6 = 4'b0010; idx6[IW +: IW] = 3'd6;
    step(); step();
    check("oor6_q", {26'd0, q6}, 32'h04);
    check("oor6_ack", {28'd0, ack6}, 32'b0010);
    check("oor6_err", {31'd0, err6}, 32'd1);
    req6 = '0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
